alu_share_arb: RTL

- Shares one integer ALU between two requesters: port 0 is the execute stage and port 1 is the branch/compare unit.
- Each port uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin, and the block sequences each operation through a registered 3-state FSM.
- Sits between decode/issue and the ALU; it instantiates the core's alu internally.

---
 rtl/alu_share_arb_pkg.sv | 44 ++++
 rtl/alu_share_arb_if.sv | 31 +++
 rtl/alu_share_arb_alu.sv | 53 +++++
 rtl/alu_share_arb.sv | 132 +++++++++++++
 4 files changed

// File: rtl/alu_share_arb_pkg.sv
// Shared ALU definitions: opcode map, arbiter FSM states, and the opcode
// legality check that decode can reuse.
package alu_share_arb_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Arithmetic space occupies 0..9, compare space 10..15, so an opcode is
  // legal in at most one space and a swapped is_cond is always caught.
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_OP_EQ   = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NE   = 4'd11;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LT   = 4'd12;
  localparam logic [ALU_OP_W-1:0] ALU_OP_GE   = 4'd13;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LTU  = 4'd14;
  localparam logic [ALU_OP_W-1:0] ALU_OP_GEU  = 4'd15;

  // Poison values the ALU returns for an opcode outside its space.
  localparam logic [31:0] ALU_BAD_COND  = 32'hbaddcafe;
  localparam logic [31:0] ALU_BAD_ARITH = 32'hdeadbeef;

  function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op,
                                        input logic                is_cond);
    logic ok;
    if (is_cond) ok = (op >= ALU_OP_EQ);
    else         ok = (op <= ALU_OP_AND);
    return ok;
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Two-port request/response bundle between the issue side (master) and the
// shared-ALU arbiter (slave).
interface alu_share_arb_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
);
  logic            req0_valid, req0_ready, req0_is_cond;
  logic [XLEN-1:0] req0_a, req0_b;
  logic [OP_W-1:0] req0_op;
  logic            req1_valid, req1_ready, req1_is_cond;
  logic [XLEN-1:0] req1_a, req1_b;
  logic [OP_W-1:0] req1_op;
  logic            rsp0_valid, rsp0_ready, rsp0_err;
  logic [XLEN-1:0] rsp0_result;
  logic            rsp1_valid, rsp1_ready, rsp1_err;
  logic [XLEN-1:0] rsp1_result;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_is_cond, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_op, req1_is_cond, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_err
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_is_cond, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, req1_is_cond, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_err
  );
endinterface

// File: rtl/alu_share_arb_alu.sv
// Core integer ALU: arithmetic ops, or branch compares returning a 0/1 flag.
module alu_share_arb_alu
  import alu_share_arb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = ALU_OP_W
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [OP_W-1:0] op_i,
  input  logic            is_cond_i,
  output logic [XLEN-1:0] result_o
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] sh;
  logic           eq, lt_s, lt_u;

  assign sh   = b_i[SHW-1:0];
  assign eq   = (a_i == b_i);
  assign lt_s = ($signed(a_i) < $signed(b_i));
  assign lt_u = (a_i < b_i);

  // Opcode decode; anything outside the selected space yields poison
  always_comb begin
    result_o = '0;
    if (is_cond_i) begin
      case (op_i)
        ALU_OP_EQ:  result_o[0] = eq;
        ALU_OP_NE:  result_o[0] = ~eq;
        ALU_OP_LT:  result_o[0] = lt_s;
        ALU_OP_GE:  result_o[0] = ~lt_s;
        ALU_OP_LTU: result_o[0] = lt_u;
        ALU_OP_GEU: result_o[0] = ~lt_u;
        default:    result_o    = XLEN'(ALU_BAD_COND);
      endcase
    end else begin
      case (op_i)
        ALU_OP_ADD:  result_o    = a_i + b_i;
        ALU_OP_SUB:  result_o    = a_i - b_i;
        ALU_OP_SLL:  result_o    = a_i << sh;
        ALU_OP_SLT:  result_o[0] = lt_s;
        ALU_OP_SLTU: result_o[0] = lt_u;
        ALU_OP_XOR:  result_o    = a_i ^ b_i;
        ALU_OP_SRL:  result_o    = a_i >> sh;
        ALU_OP_SRA:  result_o    = $unsigned($signed(a_i) >>> sh);
        ALU_OP_OR:   result_o    = a_i | b_i;
        ALU_OP_AND:  result_o    = a_i & b_i;
        default:     result_o    = XLEN'(ALU_BAD_ARITH);
      endcase
    end
  end
endmodule

// File: rtl/alu_share_arb.sv
// Round-robin share of one ALU between execute (port 0) and branch unit
// (port 1). Each op walks IDLE -> EXEC -> RESP; the ALU only ever sees the
// operands latched at the request handshake.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = ALU_OP_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  alu_share_arb_if.slave  bus
);
  logic [1:0]                 req_valid, req_ready, req_is_cond;
  logic [1:0]                 rsp_valid, rsp_ready;
  logic [1:0][XLEN-1:0]       req_a, req_b;
  logic [1:0][OP_W-1:0]       req_op;

  arb_state_e                 state_q, state_d;
  logic                       last_grant_q, last_grant_d;
  logic                       owner_q, grant, take;
  logic [XLEN-1:0]            a_q, b_q, result_q, alu_result;
  logic [OP_W-1:0]            op_q;
  logic                       is_cond_q, err_q;

  assign req_valid   = {bus.req1_valid,   bus.req0_valid};
  assign req_is_cond = {bus.req1_is_cond, bus.req0_is_cond};
  assign req_a       = {bus.req1_a,       bus.req0_a};
  assign req_b       = {bus.req1_b,       bus.req0_b};
  assign req_op      = {bus.req1_op,      bus.req0_op};
  assign rsp_ready   = {bus.rsp1_ready,   bus.rsp0_ready};

  // Round-robin pick: a lone requester wins, a tie goes to the port not served last
  always_comb begin
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = 1'b0;
    endcase
  end

  // Flush blocks acceptance so nothing slips in during an abort cycle
  assign take = (state_q == ARB_IDLE) && !flush && (req_valid != 2'b00);

  // Next-state, grant bookkeeping and request ready
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    case (state_q)
      ARB_IDLE: begin
        if (take) begin
          req_ready[grant] = 1'b1;
          state_d          = ARB_EXEC;
        end
      end
      ARB_EXEC: state_d = ARB_RESP;
      ARB_RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d      = ARB_IDLE;
          last_grant_d = owner_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // Abort wins over everything, including a same-cycle response handshake
    if (flush) begin
      state_d      = ARB_IDLE;
      last_grant_d = last_grant_q;
    end
  end

  // FSM state and fairness pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Operand latch on request handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      is_cond_q <= 1'b0;
      owner_q   <= 1'b0;
    end else if (take) begin
      a_q       <= req_a[grant];
      b_q       <= req_b[grant];
      op_q      <= req_op[grant];
      is_cond_q <= req_is_cond[grant];
      owner_q   <= grant;
    end
  end

  alu_share_arb_alu #(.XLEN(XLEN), .OP_W(OP_W)) u_alu (
    .a_i       (a_q),
    .b_i       (b_q),
    .op_i      (op_q),
    .is_cond_i (is_cond_q),
    .result_o  (alu_result)
  );

  // Result/err capture in EXEC; held steady through RESP backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (state_q == ARB_EXEC && !flush) begin
      result_q <= alu_result;
      err_q    <= ~alu_op_legal(op_q, is_cond_q);
    end
  end

  assign rsp_valid[0]    = (state_q == ARB_RESP) && !owner_q;
  assign rsp_valid[1]    = (state_q == ARB_RESP) &&  owner_q;

  assign bus.req0_ready  = req_ready[0];
  assign bus.req1_ready  = req_ready[1];
  assign bus.rsp0_valid  = rsp_valid[0];
  assign bus.rsp1_valid  = rsp_valid[1];
  assign bus.rsp0_result = rsp_valid[0] ? result_q : '0;
  assign bus.rsp1_result = rsp_valid[1] ? result_q : '0;
  assign bus.rsp0_err    = rsp_valid[0] & err_q;
  assign bus.rsp1_err    = rsp_valid[1] & err_q;
endmodule
